// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised inter-stage pipeline register chain with per-slot
//                valid, stall, flush and kill-masked side-effect control bits.
//  Revision    : 1.0 - initial release
// ============================================================================

module pipe_stage_reg #(
  parameter int                CTRL_W    = 4,
  parameter int                DATA_W    = 32,
  parameter int                STAGES    = 1,
  parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        occupancy
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("pipe_stage_reg: STAGES must be within 1..4");
    end
  endgenerate

  localparam logic [CTRL_W-1:0] c_KEEP_MASK = ~KILL_MASK;

  logic [STAGES-1:0] r_valid;
  logic [CTRL_W-1:0] r_ctrl [STAGES];
  logic [DATA_W-1:0] r_data [STAGES];
  logic [2:0]        r_occ;

  logic [STAGES-1:0] w_valid_nxt;
  logic [CTRL_W-1:0] w_ctrl_nxt [STAGES];
  logic [DATA_W-1:0] w_data_nxt [STAGES];
  logic [2:0]        w_occ_nxt;
  logic              w_move;
  logic              w_in_live;

  // Flush overrides stall: the chain still shifts, but everything becomes a bubble.
  assign w_move    = flush | ~stall;
  assign w_in_live = in_valid & ~flush;

  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < STAGES; i++) begin
      w_ctrl_nxt[i] = r_ctrl[i];
      w_data_nxt[i] = r_data[i];
    end
    if (w_move) begin
      w_valid_nxt[0] = w_in_live;
      w_ctrl_nxt[0]  = w_in_live ? in_ctrl : (in_ctrl & c_KEEP_MASK);
      w_data_nxt[0]  = in_data;
      for (int i = 1; i < STAGES; i++) begin
        w_valid_nxt[i] = r_valid[i-1] & ~flush;
        w_ctrl_nxt[i]  = flush ? (r_ctrl[i-1] & c_KEEP_MASK) : r_ctrl[i-1];
        w_data_nxt[i]  = r_data[i-1];
      end
    end
  end

  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ_nxt = w_occ_nxt + {2'b00, w_valid_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_ctrl[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_occ   <= w_occ_nxt;
      for (int i = 0; i < STAGES; i++) begin
        r_ctrl[i] <= w_ctrl_nxt[i];
        r_data[i] <= w_data_nxt[i];
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_ctrl  = r_ctrl[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign occupancy = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench driving 1/2/3/4-slot instances in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [3:0]  in_ctrl;
  logic [31:0] in_data;

  logic        v1, v2, v3, v4;
  logic [3:0]  c1, c2, c3, c4;
  logic [31:0] d1, d2, d3, d4;
  logic [2:0]  o1, o2, o3, o4;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .STAGES(1), .KILL_MASK(4'b0001)) u_s1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v1), .out_ctrl(c1),
    .out_data(d1), .occupancy(o1));
  pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .STAGES(2), .KILL_MASK(4'b0001)) u_s2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v2), .out_ctrl(c2),
    .out_data(d2), .occupancy(o2));
  pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .STAGES(3), .KILL_MASK(4'b0001)) u_s3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v3), .out_ctrl(c3),
    .out_data(d3), .occupancy(o3));
  pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .STAGES(4), .KILL_MASK(4'b0001)) u_s4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(v4), .out_ctrl(c4),
    .out_data(d4), .occupancy(o4));

  typedef struct {
    logic        v;
    logic [3:0]  ctrl;
    logic [31:0] data;
    logic [3:0]  exp_ctrl;
    logic [2:0]  exp_occ3;
  } vec_t;

  typedef struct {
    logic        v;
    logic [3:0]  ctrl;
    logic [31:0] data;
  } exp_t;

  vec_t vecs [9];
  exp_t sb_q [$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 4'b1011, 32'd1,          4'b1011, 3'd1};
    vecs[1] = '{1'b1, 4'b0101, 32'd2,          4'b0101, 3'd2};
    vecs[2] = '{1'b1, 4'b0011, 32'd3,          4'b0011, 3'd3};
    vecs[3] = '{1'b1, 4'b1000, 32'd4,          4'b1000, 3'd3};
    vecs[4] = '{1'b0, 4'b1111, 32'hAAAA5555,   4'b1110, 3'd2};
    vecs[5] = '{1'b1, 4'b0001, 32'h12345678,   4'b0001, 3'd2};
    vecs[6] = '{1'b0, 4'b0000, 32'd0,          4'b0000, 3'd1};
    vecs[7] = '{1'b0, 4'b0111, 32'd7,          4'b0110, 3'd1};
    vecs[8] = '{1'b0, 4'b0000, 32'd8,          4'b0000, 3'd0};

    // Reset for two cycles with a live input pending, then release.
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 4'b1011, 32'hDEADBEEF);
    step();
    step();
    check("rst_s1_valid", v1, 1'b0);
    check("rst_s1_ctrl",  c1, 4'b0000);
    check("rst_s1_data",  d1, 32'h0);
    check("rst_s1_occ",   o1, 3'd0);
    check("rst_s4_occ",   o4, 3'd0);
    reset = 1'b0;
    step();
    check("lat_s1_valid", v1, 1'b1);
    check("lat_s1_ctrl",  c1, 4'b1011);
    check("lat_s1_data",  d1, 32'hDEADBEEF);
    check("lat_s1_occ",   o1, 3'd1);

    // Empty every chain before the streaming table.
    flush = 1'b1;
    drive(1'b0, 4'b0000, 32'd0);
    step();
    flush = 1'b0;
    check("flush_s3_occ",   o3, 3'd0);
    check("flush_s3_valid", v3, 1'b0);

    for (int k = 0; k < 9; k++) begin
      drive(vecs[k].v, vecs[k].ctrl, vecs[k].data);
      sb_q.push_back('{vecs[k].v, vecs[k].exp_ctrl, vecs[k].data});
      step();
      check("tbl_s1_valid", v1, vecs[k].v);
      check("tbl_s1_ctrl",  c1, vecs[k].exp_ctrl);
      check("tbl_s1_data",  d1, vecs[k].data);
      check("tbl_s3_occ",   o3, vecs[k].exp_occ3);
      if (sb_q.size() == 3) begin
        e = sb_q.pop_front();
        check("sb_s3_valid", v3, e.v);
        check("sb_s3_ctrl",  c3, e.ctrl);
        check("sb_s3_data",  d3, e.data);
      end
    end

    // Stall hold on the two-slot chain: slot1=6, slot0=5.
    drive(1'b1, 4'b0011, 32'd6);
    step();
    drive(1'b1, 4'b0011, 32'd5);
    step();
    check("stl_pre_data", d2, 32'd6);
    check("stl_pre_occ",  o2, 3'd2);
    stall = 1'b1;
    drive(1'b1, 4'b0011, 32'd9);
    for (int n = 0; n < 3; n++) begin
      step();
      check("stl_hold_data",  d2, 32'd6);
      check("stl_hold_occ",   o2, 3'd2);
      check("stl_hold_valid", v2, 1'b1);
    end
    stall = 1'b0;
    step();
    check("stl_rel_data", d2, 32'd5);
    check("stl_rel_occ",  o2, 3'd2);
    drive(1'b0, 4'b0000, 32'd0);
    step();
    check("stl_in9_data",  d2, 32'd9);
    check("stl_in9_valid", v2, 1'b1);
    check("stl_in9_occ",   o2, 3'd1);

    // Flush together with stall: flush must win.
    drive(1'b1, 4'b0011, 32'd10);
    step();
    drive(1'b1, 4'b0011, 32'd11);
    step();
    check("fs_pre_occ",  o2, 3'd2);
    check("fs_pre_data", d2, 32'd10);
    flush = 1'b1; stall = 1'b1;
    step();
    check("fs_s2_valid", v2, 1'b0);
    check("fs_s2_ctrl",  c2, 4'b0010);
    check("fs_s2_occ",   o2, 3'd0);
    check("fs_s4_occ",   o4, 3'd0);
    flush = 1'b0; stall = 1'b0;

    // Mid-stream reset on the four-slot chain while stalled.
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, 4'b1011, 32'd20 + 32'(n));
      step();
    end
    check("mr_pre_occ",   o4, 3'd4);
    check("mr_pre_data",  d4, 32'd20);
    check("mr_pre_valid", v4, 1'b1);
    reset = 1'b1; stall = 1'b1;
    drive(1'b1, 4'b1011, 32'd24);
    step();
    check("mr_s4_valid", v4, 1'b0);
    check("mr_s4_ctrl",  c4, 4'b0000);
    check("mr_s4_data",  d4, 32'h0);
    check("mr_s4_occ",   o4, 3'd0);
    reset = 1'b0; stall = 1'b0;
    drive(1'b1, 4'b1011, 32'h55);
    step();
    check("mr_lat_e1", v4, 1'b0);
    drive(1'b0, 4'b0000, 32'd0);
    for (int n = 0; n < 2; n++) begin
      step();
      check("mr_lat_early", v4, 1'b0);
    end
    step();
    check("mr_lat_valid", v4, 1'b1);
    check("mr_lat_data",  d4, 32'h55);
    check("mr_lat_ctrl",  c4, 4'b1011);
    check("mr_lat_occ",   o4, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
